// File: rtl/md_pkg.sv
// Shared encodings and types for the iterative multiply/divide unit.
package md_pkg;

  localparam int unsigned MD_OP_W = 3;

  // Operation encodings as presented by decode.
  typedef enum logic [MD_OP_W-1:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Context latched at accept and consumed in FIX.
  typedef struct packed {
    md_op_e op;
    logic   sign_a;
    logic   sign_b;
    logic   div_zero;
  } md_ctx_t;

endpackage

// File: rtl/md_if.sv
// Decode-side request/response bundle for md_unit.
interface md_if #(
  parameter int unsigned WIDTH = 32
);
  import md_pkg::*;

  logic [MD_OP_W-1:0] md_op;
  logic               md_valid;
  logic               md_ready;
  logic [WIDTH-1:0]   md_a;
  logic [WIDTH-1:0]   md_b;
  logic               flush;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output md_op, md_valid, md_a, md_b, flush,
    input  md_ready, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  md_op, md_valid, md_a, md_b, flush,
    output md_ready, busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/md_abs.sv
// Combinational magnitude and sign extraction for one operand.
module md_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag_c_o,
  output logic             neg_c_o
);

  // Unsigned ops pass through; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign neg_c_o = signed_i & val_i[WIDTH-1];
  assign mag_c_o = neg_c_o ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/md_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers.
// WIDTH must be at least 4.
module md_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  md_if.slave md
);
  import md_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned WP1   = WIDTH + 1;

  md_state_e        state_q, state_d;
  md_ctx_t          ctx_q, ctx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product upper half / remainder
  logic [WIDTH-1:0] sh_q, sh_d;       // multiplier / quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_raw_q, a_raw_d; // dividend as issued, for divide-by-zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  md_op_e           op_in;
  logic             is_mul_in, is_arith_in, is_signed_in;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_a, sign_b;

  logic             is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_s;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  logic [W2-1:0]    neg_inv;
  logic [WIDTH:0]   neg_lo;
  logic [WIDTH-1:0] neg_hi;
  logic             neg_hi_cin;
  logic             neg_hi_sel, neg_lo_sel;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  // Incoming operation decode.
  assign op_in        = md_op_e'(md.md_op);
  assign is_mul_in    = (op_in == MD_MULT) || (op_in == MD_MULTU);
  assign is_arith_in  = is_mul_in || (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign is_signed_in = (op_in == MD_MULT) || (op_in == MD_DIV);

  md_abs #(.WIDTH(WIDTH)) u_abs_a (
    .val_i    (md.md_a),
    .signed_i (is_signed_in),
    .mag_c_o  (mag_a),
    .neg_c_o  (sign_a)
  );

  md_abs #(.WIDTH(WIDTH)) u_abs_b (
    .val_i    (md.md_b),
    .signed_i (is_signed_in),
    .mag_c_o  (mag_b),
    .neg_c_o  (sign_b)
  );

  assign is_mul = (ctx_q.op == MD_MULT) || (ctx_q.op == MD_MULTU);

  // One iteration step for each algorithm.
  assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : WP1'(0));
  assign div_rem_s = {acc_q, sh_q[WIDTH-1]};
  assign div_ge    = div_rem_s >= {1'b0, opnd_q};
  // Only used when div_ge, so the true difference fits in WIDTH bits.
  assign div_diff  = div_rem_s[WIDTH-1:0] - opnd_q;

  // Shared 2W negator; the mid carry is broken for divide so the
  // remainder and quotient halves are negated independently.
  assign neg_inv    = ~{acc_q, sh_q};
  assign neg_lo     = {1'b0, neg_inv[WIDTH-1:0]} + WP1'(1);
  assign neg_hi_cin = ~is_mul | neg_lo[WIDTH];
  assign neg_hi     = neg_inv[W2-1:WIDTH] + WIDTH'(neg_hi_cin);

  assign neg_lo_sel = ctx_q.sign_a ^ ctx_q.sign_b;
  assign neg_hi_sel = is_mul ? (ctx_q.sign_a ^ ctx_q.sign_b) : ctx_q.sign_a;
  assign fix_hi     = neg_hi_sel ? neg_hi : acc_q;
  assign fix_lo     = neg_lo_sel ? neg_lo[WIDTH-1:0] : sh_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
      a_raw_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opnd_q  <= opnd_d;
      a_raw_q <= a_raw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opnd_d  = opnd_q;
    a_raw_d = a_raw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    if (md.flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.md_valid) begin
            if (op_in == MD_MTHI) begin
              hi_d = md.md_a;
            end else if (op_in == MD_MTLO) begin
              lo_d = md.md_a;
            end else if (is_arith_in) begin
              ctx_d.op       = op_in;
              ctx_d.sign_a   = sign_a;
              ctx_d.sign_b   = sign_b;
              ctx_d.div_zero = !is_mul_in && (md.md_b == '0);
              acc_d          = '0;
              sh_d           = is_mul_in ? mag_b : mag_a;
              opnd_d         = is_mul_in ? mag_a : mag_b;
              a_raw_d        = md.md_a;
              cnt_d          = '0;
              busy_d         = 1'b1;
              state_d        = CALC;
            end
          end
        end
        CALC: begin
          if (is_mul) begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
          end else begin
            acc_d = div_ge ? div_diff : div_rem_s[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_ge};
          end
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          if (ctx_q.div_zero) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = fix_hi;
            lo_d = fix_lo;
          end
          done_d  = 1'b1;
          dz_d    = ctx_q.div_zero;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign md.md_ready = ~busy_q;
  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.div_zero = dz_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit at WIDTH=32 and WIDTH=8.
module tb_md_unit;
  import md_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;

  always #5 clk = ~clk;

  md_if #(.WIDTH(W))  bus  ();
  md_if #(.WIDTH(W8)) bus8 ();

  md_unit #(.WIDTH(W))  dut   (.clk(clk), .rst_n(rst_n),  .md(bus));
  md_unit #(.WIDTH(W8)) dut8  (.clk(clk), .rst_n(rst8_n), .md(bus8));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] hi, input logic [31:0] lo,
                                  input logic dz);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    return e;
  endfunction

  // Reference behaviour using native 64-bit arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t            e;
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
    end else if (op == MD_MULT) begin
      p = sa * sb;
      {e.hi, e.lo} = p;
    end else if (op == MD_MULTU) begin
      up = ua * ub;
      {e.hi, e.lo} = up;
    end else if (op == MD_DIV) begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end else begin
      e.lo = 32'(ua / ub);
      e.hi = 32'(ua % ub);
    end
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (bus.md_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready", bus.md_ready, 1);
    bus.md_op    = op;
    bus.md_a     = a;
    bus.md_b     = b;
    bus.md_valid = 1'b1;
    @(posedge clk); #1;
    bus.md_valid = 1'b0;
    bus.md_op    = MD_NOP;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = (bus.done === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
    end
  endtask

  task automatic sb_compare(input string name, input int lat);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb_empty actual=done required=no_done", name);
      return;
    end
    e = sb_q.pop_front();
    check({name, "_hi"}, bus.hi, e.hi);
    check({name, "_lo"}, bus.lo, e.lo);
    check({name, "_dz"}, bus.div_zero, e.dz);
    check({name, "_lat"}, 64'(lat), 64'(W + 1));
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    int lat;
    bit ok;
    issue(op, a, b);
    sb_q.push_back(e);
    wait_done(lat, ok);
    if (ok) sb_compare(name, lat);
    else    void'(sb_q.pop_front());
    @(posedge clk); #1;
    check({name, "_done_pulse"}, bus.done, 0);
    check({name, "_dz_pulse"}, bus.div_zero, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int          lat;
    bit          ok;
    int          dcount;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{MD_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{MD_MULTU, 32'h1234_5678, 32'd0,         32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};

    rst_n         = 1'b0;
    rst8_n        = 1'b0;
    bus.md_op     = MD_NOP;
    bus.md_valid  = 1'b0;
    bus.md_a      = '0;
    bus.md_b      = '0;
    bus.flush     = 1'b0;
    bus8.md_op    = MD_NOP;
    bus8.md_valid = 1'b0;
    bus8.md_a     = '0;
    bus8.md_b     = '0;
    bus8.flush    = 1'b0;

    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    check("rst_ready", bus.md_ready, 1);
    @(negedge clk);
    rst_n  = 1'b1;
    rst8_n = 1'b1;
    @(posedge clk); #1;

    // MTHI / MTLO complete at the accepting edge.
    issue(MD_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", bus.hi, 32'h1234);
    check("mthi_busy", bus.busy, 0);
    check("mthi_done", bus.done, 0);
    issue(MD_MTLO, 32'h0000_5678, 32'd0);
    check("mtlo_lo", bus.lo, 32'h5678);
    check("mtlo_hi", bus.hi, 32'h1234);
    check("mtlo_done", bus.done, 0);

    // Directed vector table.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             mk_exp(vecs[i].hi, vecs[i].lo, vecs[i].dz));

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(4, 1));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(20, 1)) : $urandom);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // Ops while busy are ignored; a held op is taken in the done cycle.
    issue(MD_MTHI, 32'hAAAA_0000, 32'd0);
    issue(MD_MTLO, 32'h0000_BBBB, 32'd0);
    issue(MD_MULT, 32'd3, 32'd5);
    sb_q.push_back(mk_exp(32'd0, 32'd15, 1'b0));
    @(posedge clk); #1;
    bus.md_op    = MD_MTHI;
    bus.md_a     = 32'hDEAD_0000;
    bus.md_valid = 1'b1;
    @(posedge clk); #1;
    check("busy_mthi_ignored", bus.hi, 32'hAAAA_0000);
    check("busy_held", bus.busy, 1);
    bus.md_op = MD_MULT;
    bus.md_a  = 32'd100;
    bus.md_b  = 32'd100;
    wait_done(lat, ok);
    if (ok) sb_compare("b2b_first", lat + 2);
    else    void'(sb_q.pop_front());
    check("b2b_ready", bus.md_ready, 1);
    @(posedge clk); #1;
    bus.md_valid = 1'b0;
    bus.md_op    = MD_NOP;
    check("b2b_accepted", bus.busy, 1);
    sb_q.push_back(mk_exp(32'd0, 32'd10000, 1'b0));
    wait_done(lat, ok);
    if (ok) sb_compare("b2b_second", lat);
    else    void'(sb_q.pop_front());
    @(posedge clk); #1;

    // Flush during CALC.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("flc_busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flc_busy", bus.busy, 0);
    check("flc_ready", bus.md_ready, 1);
    check("flc_done", bus.done, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcount++;
    end
    check("flc_no_done", 64'(dcount), 0);
    check("flc_hi", bus.hi, 32'd0);
    check("flc_lo", bus.lo, 32'd10000);

    // Flush in the FIX cycle suppresses the write.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (W) begin
      @(posedge clk); #1;
    end
    check("flf_busy_before", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flf_done", bus.done, 0);
    check("flf_busy", bus.busy, 0);
    check("flf_hi", bus.hi, 32'd0);
    check("flf_lo", bus.lo, 32'd10000);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dcount++;
    end
    check("flf_no_done", 64'(dcount), 0);

    // Flush with an MT op in IDLE blocks the write.
    bus.md_op    = MD_MTHI;
    bus.md_a     = 32'h1111_1111;
    bus.md_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.md_valid = 1'b0;
    bus.md_op    = MD_NOP;
    bus.flush    = 1'b0;
    check("fli_hi", bus.hi, 32'd0);
    check("fli_busy", bus.busy, 0);

    // Normal operation resumes after flushes.
    run_op("post_flush", MD_DIVU, 32'd100, 32'd7, mk_exp(32'd2, 32'd14, 1'b0));

    // WIDTH=8 instance: signed corner and asynchronous reset.
    bus8.md_op    = MD_MULT;
    bus8.md_a     = 8'h80;
    bus8.md_b     = 8'h80;
    bus8.md_valid = 1'b1;
    @(posedge clk); #1;
    bus8.md_valid = 1'b0;
    bus8.md_op    = MD_NOP;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_lat", 64'(lat), 64'(W8 + 1));
    check("w8_hi", bus8.hi, 8'h40);
    check("w8_lo", bus8.lo, 8'h00);
    @(posedge clk); #1;
    bus8.md_op    = MD_MULT;
    bus8.md_a     = 8'd3;
    bus8.md_b     = 8'd5;
    bus8.md_valid = 1'b1;
    @(posedge clk); #1;
    bus8.md_valid = 1'b0;
    bus8.md_op    = MD_NOP;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("w8_busy_before", bus8.busy, 1);
    #2;
    rst8_n = 1'b0;
    #1;
    check("w8_arst_hi", bus8.hi, 0);
    check("w8_arst_lo", bus8.lo, 0);
    check("w8_arst_busy", bus8.busy, 0);
    check("w8_arst_done", bus8.done, 0);
    check("w8_arst_dz", bus8.div_zero, 0);
    check("w8_arst_ready", bus8.md_ready, 1);
    rst8_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers; the sequential companion to the single-cycle ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from decode, runs a radix-2 shift-add or restoring-divide loop for WIDTH cycles, and holds results in HI/LO for MFHI/MFLO. A valid/ready handshake lets the pipeline stall on `busy`, and `flush` aborts on exceptions.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `md_op`  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- `md_valid`  in  1  `md_op`/operands valid this cycle.
- `md_ready`  out  1  unit can accept; equals `!busy`.
- `md_a`  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- `md_b`  in  WIDTH  rt operand (multiplier / divisor).
- `flush`  in  1  abort in-flight operation.
- `busy`  out  1  iteration in progress.
- `done`  out  1  one-cycle pulse: MULT/DIV result now in HI/LO.
- `div_zero`  out  1  one-cycle pulse with `done` when the divisor was 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, FSM=IDLE, counter=0.
- Accept: `md_valid & md_ready` at a rising edge with a non-NOP op.
- MTHI/MTLO complete at the accepting edge. They write `hi`/`lo` ← `md_a`, do not raise `busy`, and do not pulse `done`.
- FSM states are IDLE → CALC → FIX → IDLE.
- IDLE, on accepting an arithmetic op:
  - latch op;
  - latch magnitudes: |a|, |b| for signed ops, raw values for unsigned;
  - latch sign bits; clear the accumulator; counter=0; go to CALC.
- CALC, multiply: if multiplier LSB is set, add the multiplicand into the upper accumulator half. Shift the 2·WIDTH {acc,mplier} right by 1.
- CALC, divide: shift {rem,quot} left by 1. Trial-subtract the divisor; if non-negative, keep the difference and set quot LSB.
- CALC runs for exactly WIDTH iterations, counter 0..WIDTH-1, then goes to FIX.
- FIX, signed ops:
  - negate the 2·WIDTH product if sign(a)^sign(b);
  - negate the quotient if sign(a)^sign(b);
  - negate the remainder if sign(a), so the remainder follows the dividend's sign.
- FIX writes HI/LO:
  - MULT/MULTU: HI=product[2W-1:W], LO=product[W-1:0].
  - DIV/DIVU: HI=remainder, LO=quotient.
- Divide by zero (`md_b`==0, checked at accept): skip FIX sign correction and force LO={WIDTH{1}}, HI=`md_a`. Pulse `div_zero` with `done`. Timing is unchanged.
- Signed overflow, -2^(W-1) / -1, gives LO=-2^(W-1) and HI=0. No trap.
- Unsigned WIDTH-bit magnitude handling of -2^(W-1) is exact; no extra bit is needed.

## Timing
- Accept at edge k. `busy`=1 after edge k.
- Iterations occur at edges k+1 … k+WIDTH. The FIX write happens at edge k+WIDTH+1.
- After edge k+WIDTH+1: `hi`/`lo` are updated, `done`=1 for one cycle, `busy`=0, `md_ready`=1.
- Latency is WIDTH+1 edges (33 at WIDTH=32). A back-to-back op may be accepted in the `done` cycle.
- `md_valid` while `busy` is ignored. The producer must hold the op until `md_ready`.
- `flush` has priority over everything at that edge:
  - FSM→IDLE, `busy`→0;
  - no `done`;
  - HI/LO keep their pre-op values.
- `flush` with `md_valid` in IDLE: the op is not accepted. MTHI/MTLO are also suppressed.
- `flush` in the FIX cycle: the write is suppressed.
- `rst_n` low mid-operation: immediate return to reset values, with no dependence on `clk`.
- `hi`/`lo` are registered outputs and change only at accept (MT*) or FIX edges.

## Structure
- Package `md_pkg`:
  - op encodings MD_NOP…MD_MTLO (3-bit);
  - FSM state enum {IDLE, CALC, FIX}.
- Sub-module `md_abs` #(WIDTH): combinational magnitude plus sign-flag extraction. It is instantiated twice, for a and b.
- Negation in FIX reuses one shared 2·WIDTH two's-complement negator.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 edges HI=0xFFFFFFFE, LO=0x00000001, `done` high one cycle.
- MULT -3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5, `div_zero` pulse.
- Handshake:
  - MTHI 0x1234 then MTLO 0x5678 in IDLE → each visible the next cycle, no `done`;
  - a second MULT asserted while `busy` is not accepted;
  - a back-to-back MULT in the `done` cycle is accepted.
- Start DIVU, assert `flush` at iteration 10 → `busy` drops next cycle, no `done`, HI/LO unchanged. Repeat with `flush` in the FIX cycle.
- WIDTH=8 build: MULT 0x80 × 0x80 → HI=0x40, LO=0x00 after 9 edges. Assert `rst_n` low mid-CALC → all outputs 0 asynchronously.
